// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg
//   Shared definitions for the push-button front end: the per-channel hold
//   state encoding and a helper that sizes counters from their terminal count.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        HOLD_IDLE   = 2'd0,
        HOLD_HELD   = 2'd1,
        HOLD_REPEAT = 2'd2
    } hold_state_e;

    // Default timing, in MP3_SCLK cycles.
    localparam int unsigned DEF_DEBOUNCE_CYC     = 20000;
    localparam int unsigned DEF_REPEAT_DELAY_CYC = 500000;
    localparam int unsigned DEF_REPEAT_RATE_CYC  = 100000;

    // Width of a counter that runs 0 .. n-1 and clears at n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// btn_channel
//   One button channel: 2-flop synchroniser, debounce counter and hold FSM.
//   Ports:
//     clk_i        MP3_SCLK
//     rst_i        synchronous active-high reset
//     raw_i        raw asynchronous button input, active-high
//     repeat_en_i  allows repeat_o pulses on this channel
//     level_o      debounced level
//     press_o      one-cycle pulse in the first cycle level_o is high
//     long_o       high while held past the repeat delay
//     repeat_o     one-cycle auto-repeat pulses (gated by repeat_en_i)
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int unsigned REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned HW = max_u(cnt_width(REPEAT_DELAY_CYC), cnt_width(REPEAT_RATE_CYC));
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY_CYC - 1);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE_CYC - 1);

    logic          sync1_q, sync2_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic [HW-1:0] hcnt_q;
    hold_state_e   state_q;
    logic          press_q, long_q, repeat_q;
    logic          rise, fall;

    // Debounce: a level change is accepted only after DEBOUNCE_CYC consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Edges are taken from the next-state level so press_o lines up with the
    // first cycle the registered level is high.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Hold FSM with registered pulse/flag outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= HOLD_IDLE;
            hcnt_q   <= '0;
            press_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            press_q  <= 1'b0;
            repeat_q <= 1'b0;
            if (fall) begin
                // Release wins over any terminal count in the same cycle.
                state_q <= HOLD_IDLE;
                hcnt_q  <= '0;
                long_q  <= 1'b0;
            end else begin
                case (state_q)
                    HOLD_IDLE: begin
                        if (rise) begin
                            state_q <= HOLD_HELD;
                            hcnt_q  <= '0;
                            press_q <= 1'b1;
                        end
                    end
                    HOLD_HELD: begin
                        if (hcnt_q == DELAY_LAST) begin
                            state_q  <= HOLD_REPEAT;
                            hcnt_q   <= '0;
                            long_q   <= 1'b1;
                            repeat_q <= repeat_en_i;
                        end else begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                    end
                    HOLD_REPEAT: begin
                        if (hcnt_q == RATE_LAST) begin
                            hcnt_q   <= '0;
                            repeat_q <= repeat_en_i;
                        end else begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= HOLD_IDLE;
                        hcnt_q  <= '0;
                        long_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign level_o  = level_q;
    assign press_o  = press_q;
    assign long_o   = long_q;
    assign repeat_o = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Push-button front end: N_BTN independent channels, each synchronised,
//   debounced and tracked for press / long-press / auto-repeat.
//   Ports:
//     MP3_SCLK    clock
//     RESET       synchronous active-high reset
//     BTN_RAW     raw asynchronous buttons, active-high (bit 0 = SUSPEND)
//     BTN_LEVEL   debounced levels
//     BTN_PRESS   one-cycle press pulses
//     BTN_LONG    high while held past REPEAT_DELAY_CYC
//     BTN_REPEAT  one-cycle auto-repeat pulses, masked by REPEAT_MASK
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned          N_BTN            = 5,
    parameter int unsigned          DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int unsigned          REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int unsigned          REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter logic [N_BTN-1:0]     REPEAT_MASK      = 5'b11000
) (
    input  logic             MP3_SCLK,
    input  logic             RESET,
    input  logic [N_BTN-1:0] BTN_RAW,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_LONG,
    output logic [N_BTN-1:0] BTN_REPEAT
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_ch (
            .clk_i       (MP3_SCLK),
            .rst_i       (RESET),
            .raw_i       (BTN_RAW[i]),
            .repeat_en_i (REPEAT_MASK[i]),
            .level_o     (BTN_LEVEL[i]),
            .press_o     (BTN_PRESS[i]),
            .long_o      (BTN_LONG[i]),
            .repeat_o    (BTN_REPEAT[i])
        );
    end

endmodule
